// File: rtl/mrf_responder.sv
// Matrix register file responder: three zero-latency read ports, one row write port,
// per-register pending-write tracking, and a row-by-row register zeroing engine.
// Optional read-protocol checker is built when MRF_PROTOCOL_CHECK_EN is defined.
module mrf_responder #(
   parameter int N_REGS     = 8,
   parameter int MESH_WIDTH = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                                    clk_i,
   input  logic                                    rst_i,
   input  logic [$clog2(N_REGS)-1:0]               weight_raddr_i,
   input  logic [$clog2(MESH_WIDTH)-1:0]           weight_rrowaddr_i,
   input  logic                                    weight_rdata_ready_i,
   input  logic                                    weight_rlast_i,
   output logic [DATA_WIDTH*MESH_WIDTH-1:0]        weight_rdata_o,
   output logic                                    weight_rdata_valid_o,
   input  logic [$clog2(N_REGS)-1:0]               data_raddr_i,
   input  logic [$clog2(MESH_WIDTH)-1:0]           data_rrowaddr_i,
   input  logic                                    data_rdata_ready_i,
   input  logic                                    data_rlast_i,
   output logic [DATA_WIDTH*MESH_WIDTH-1:0]        data_rdata_o,
   output logic                                    data_rdata_valid_o,
   input  logic [$clog2(N_REGS)-1:0]               acc_raddr_i,
   input  logic [$clog2(MESH_WIDTH)-1:0]           acc_rrowaddr_i,
   input  logic                                    acc_rdata_ready_i,
   input  logic                                    acc_rlast_i,
   output logic [DATA_WIDTH*MESH_WIDTH-1:0]        acc_rdata_o,
   output logic                                    acc_rdata_valid_o,
   input  logic [$clog2(N_REGS)-1:0]               res_waddr_i,
   input  logic [$clog2(MESH_WIDTH)-1:0]           res_wrowaddr_i,
   input  logic [DATA_WIDTH*MESH_WIDTH-1:0]        res_wdata_i,
   input  logic                                    res_we_i,
   input  logic                                    res_wlast_i,
   output logic                                    res_wready_o,
   input  logic                                    reserve_i,
   input  logic [$clog2(N_REGS)-1:0]               reserve_reg_i,
   input  logic                                    zero_i,
   input  logic [$clog2(N_REGS)-1:0]               zero_reg_i,
   output logic                                    zero_ready_o,
   output logic                                    zero_done_o,
   output logic [2:0]                              proto_err_o
);

   localparam int N_ROWS = MESH_WIDTH;
   localparam int RLEN   = DATA_WIDTH * MESH_WIDTH;
   localparam int AW     = $clog2(N_REGS);
   localparam int RW     = $clog2(N_ROWS);
   localparam int N_PORT = 3;

   typedef enum logic {IDLE, ZERO} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              w_zero_start;
   logic              w_zero_last;
   logic [AW-1:0]     r_zreg;
   logic [RW-1:0]     r_zrow;
   logic [RLEN-1:0]   r_mem [N_REGS][N_ROWS];
   logic [N_REGS-1:0] r_pend;
   logic [N_REGS-1:0] w_pend_nxt;
   logic              w_wbeat;

   logic [AW-1:0]     w_raddr  [N_PORT];
   logic [RW-1:0]     w_rrow   [N_PORT];
   logic              w_rvalid [N_PORT];
   logic [RLEN-1:0]   w_rdata  [N_PORT];

   assign w_raddr[0] = weight_raddr_i;
   assign w_raddr[1] = data_raddr_i;
   assign w_raddr[2] = acc_raddr_i;
   assign w_rrow[0]  = weight_rrowaddr_i;
   assign w_rrow[1]  = data_rrowaddr_i;
   assign w_rrow[2]  = acc_rrowaddr_i;

   assign weight_rdata_o       = w_rdata[0];
   assign data_rdata_o         = w_rdata[1];
   assign acc_rdata_o          = w_rdata[2];
   assign weight_rdata_valid_o = w_rvalid[0];
   assign data_rdata_valid_o   = w_rvalid[1];
   assign acc_rdata_valid_o    = w_rvalid[2];

   // NOTE: every variable written here gets its default first, so no latch is inferred.
   always_comb begin
      w_state_nxt  = r_state;
      w_zero_start = 1'b0;
      w_zero_last  = 1'b0;
      case (r_state)
         IDLE: begin
            if (zero_i) begin
               w_zero_start = 1'b1;
               w_state_nxt  = ZERO;
            end
         end
         ZERO: begin
            if (r_zrow == RW'(N_ROWS - 1)) begin
               w_zero_last = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign res_wready_o = (r_state == IDLE);
   assign zero_ready_o = (r_state == IDLE);
   // A reset landing on the final zero cycle aborts it, so the pulse is suppressed too.
   assign zero_done_o  = w_zero_last & ~rst_i;
   assign w_wbeat      = res_we_i & res_wready_o;

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_zreg  <= '0;
         r_zrow  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_zero_start) begin
            r_zreg <= zero_reg_i;
            r_zrow <= '0;
         end else if (r_state == ZERO) begin
            r_zrow <= r_zrow + RW'(1);
         end
      end
   end

   // NOTE: the array is deliberately reset; readers rely on all rows reading 0 after reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int g = 0; g < N_REGS; g++) begin
            for (int r = 0; r < N_ROWS; r++) begin
               r_mem[g][r] <= '0;
            end
         end
      end else if (r_state == ZERO) begin
         r_mem[r_zreg][r_zrow] <= '0;
      end else if (w_wbeat) begin
         r_mem[res_waddr_i][res_wrowaddr_i] <= res_wdata_i;
      end
   end

   // The reservation is applied after the clear so a same-cycle set wins.
   always_comb begin
      w_pend_nxt = r_pend;
      if (w_wbeat && res_wlast_i) begin
         w_pend_nxt[res_waddr_i] = 1'b0;
      end
      if (reserve_i) begin
         w_pend_nxt[reserve_reg_i] = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_pend <= '0;
      end else begin
         r_pend <= w_pend_nxt;
      end
   end

   always_comb begin
      for (int p = 0; p < N_PORT; p++) begin
         w_rvalid[p] = ~r_pend[w_raddr[p]] & ~((r_state == ZERO) && (r_zreg == w_raddr[p]));
         w_rdata[p]  = r_mem[w_raddr[p]][w_rrow[p]];
      end
   end

`ifdef MRF_PROTOCOL_CHECK_EN
   logic          w_rready [N_PORT];
   logic          w_rlast  [N_PORT];
   logic [RW-1:0] r_exp_row [N_PORT];
   logic [2:0]    r_err;

   assign w_rready[0] = weight_rdata_ready_i;
   assign w_rready[1] = data_rdata_ready_i;
   assign w_rready[2] = acc_rdata_ready_i;
   assign w_rlast[0]  = weight_rlast_i;
   assign w_rlast[1]  = data_rlast_i;
   assign w_rlast[2]  = acc_rlast_i;

   // Each port must walk rows 0..N_ROWS-1 in order, with rlast exactly on the final row.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_err <= '0;
         for (int p = 0; p < N_PORT; p++) begin
            r_exp_row[p] <= '0;
         end
      end else begin
         for (int p = 0; p < N_PORT; p++) begin
            if (w_rvalid[p] && w_rready[p]) begin
               if ((w_rrow[p] != r_exp_row[p]) ||
                   (w_rlast[p] != (w_rrow[p] == RW'(N_ROWS - 1)))) begin
                  r_err[p] <= 1'b1;
               end
               r_exp_row[p] <= w_rlast[p] ? '0 : r_exp_row[p] + RW'(1);
            end
         end
      end
   end

   assign proto_err_o = r_err;
`else
   logic w_unused_proto;
   assign w_unused_proto = ^{weight_rdata_ready_i, weight_rlast_i,
                             data_rdata_ready_i, data_rlast_i,
                             acc_rdata_ready_i, acc_rlast_i};
   assign proto_err_o = 3'b000;
`endif

endmodule

// File: tb/tb_mrf_responder.sv
// Self-checking bench for mrf_responder: a register-file model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_mrf_responder;

   localparam int N_REGS = 8;
   localparam int N_ROWS = 4;
   localparam int RLEN   = 128;
   localparam int AW     = 3;
   localparam int RW     = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst_i;
   logic [AW-1:0]   p_raddr  [3];
   logic [RW-1:0]   p_rrow   [3];
   logic            p_rready [3];
   logic            p_rlast  [3];
   logic [RLEN-1:0] p_rdata  [3];
   logic            p_rvalid [3];
   logic [AW-1:0]   res_waddr;
   logic [RW-1:0]   res_wrow;
   logic [RLEN-1:0] res_wdata;
   logic            res_we, res_wlast, res_wready;
   logic            reserve, zero, zero_ready, zero_done;
   logic [AW-1:0]   reserve_reg, zero_reg;
   logic [2:0]      proto_err;

   mrf_responder dut (
      .clk_i(clk), .rst_i(rst_i),
      .weight_raddr_i(p_raddr[0]), .weight_rrowaddr_i(p_rrow[0]),
      .weight_rdata_ready_i(p_rready[0]), .weight_rlast_i(p_rlast[0]),
      .weight_rdata_o(p_rdata[0]), .weight_rdata_valid_o(p_rvalid[0]),
      .data_raddr_i(p_raddr[1]), .data_rrowaddr_i(p_rrow[1]),
      .data_rdata_ready_i(p_rready[1]), .data_rlast_i(p_rlast[1]),
      .data_rdata_o(p_rdata[1]), .data_rdata_valid_o(p_rvalid[1]),
      .acc_raddr_i(p_raddr[2]), .acc_rrowaddr_i(p_rrow[2]),
      .acc_rdata_ready_i(p_rready[2]), .acc_rlast_i(p_rlast[2]),
      .acc_rdata_o(p_rdata[2]), .acc_rdata_valid_o(p_rvalid[2]),
      .res_waddr_i(res_waddr), .res_wrowaddr_i(res_wrow), .res_wdata_i(res_wdata),
      .res_we_i(res_we), .res_wlast_i(res_wlast), .res_wready_o(res_wready),
      .reserve_i(reserve), .reserve_reg_i(reserve_reg),
      .zero_i(zero), .zero_reg_i(zero_reg),
      .zero_ready_o(zero_ready), .zero_done_o(zero_done),
      .proto_err_o(proto_err)
   );

   int n_cmp  = 0;
   int n_fail = 0;
   bit cmp_en = 1'b0;

   task automatic check(input string name, input logic [RLEN-1:0] act, input logic [RLEN-1:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [RLEN-1:0] m_mem [N_REGS][N_ROWS];
   bit              m_pend [N_REGS];
   int              m_zero_left;   // rows still to be cleared; 0 means idle
   int              m_zero_reg;
   int              m_exp_row [3];
   logic [2:0]      m_err;

   function automatic bit m_valid(input int p);
      return !m_pend[p_raddr[p]] && !(m_zero_left > 0 && m_zero_reg == int'(p_raddr[p]));
   endfunction

   always @(posedge clk) begin
      bit beat [3];
      for (int p = 0; p < 3; p++) beat[p] = m_valid(p) && p_rready[p];
      if (rst_i) begin
         for (int g = 0; g < N_REGS; g++) begin
            m_pend[g] = 1'b0;
            for (int r = 0; r < N_ROWS; r++) m_mem[g][r] = '0;
         end
         m_zero_left = 0;
         m_zero_reg  = 0;
         m_err       = 3'b000;
         for (int p = 0; p < 3; p++) m_exp_row[p] = 0;
      end else begin
         for (int p = 0; p < 3; p++) begin
            if (beat[p]) begin
               if (int'(p_rrow[p]) != m_exp_row[p] || (p_rlast[p] != (int'(p_rrow[p]) == N_ROWS - 1)))
                  m_err[p] = 1'b1;
               m_exp_row[p] = p_rlast[p] ? 0 : (m_exp_row[p] + 1) % N_ROWS;
            end
         end
         if (m_zero_left > 0) begin
            m_mem[m_zero_reg][N_ROWS - m_zero_left] = '0;
            m_zero_left--;
         end else begin
            if (res_we) begin
               m_mem[res_waddr][res_wrow] = res_wdata;
               if (res_wlast) m_pend[res_waddr] = 1'b0;
            end
            if (zero) begin
               m_zero_reg  = int'(zero_reg);
               m_zero_left = N_ROWS;
            end
         end
         if (reserve) m_pend[reserve_reg] = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         for (int p = 0; p < 3; p++) begin
            check($sformatf("model_p%0d_valid", p), RLEN'(p_rvalid[p]), RLEN'(m_valid(p)));
            check($sformatf("model_p%0d_rdata", p), p_rdata[p], m_mem[p_raddr[p]][p_rrow[p]]);
         end
         check("model_wready", RLEN'(res_wready), RLEN'(m_zero_left == 0));
         check("model_zero_ready", RLEN'(zero_ready), RLEN'(m_zero_left == 0));
         check("model_zero_done", RLEN'(zero_done), RLEN'(m_zero_left == 1 && !rst_i));
`ifdef MRF_PROTOCOL_CHECK_EN
         check("model_proto_err", RLEN'(proto_err), RLEN'(m_err));
`else
         check("model_proto_err", RLEN'(proto_err), RLEN'(3'b000));
`endif
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic wr(input int a, input int r, input logic [RLEN-1:0] d, input bit last);
      res_waddr = AW'(a);
      res_wrow  = RW'(r);
      res_wdata = d;
      res_wlast = last;
      res_we    = 1'b1;
      tick();
      res_we    = 1'b0;
      res_wlast = 1'b0;
   endtask

   logic [RLEN-1:0] v;

   initial begin
      rst_i = 1'b1;
      for (int p = 0; p < 3; p++) begin
         p_raddr[p] = '0; p_rrow[p] = '0; p_rready[p] = 1'b0; p_rlast[p] = 1'b0;
      end
      res_waddr = '0; res_wrow = '0; res_wdata = '0; res_we = 1'b0; res_wlast = 1'b0;
      reserve = 1'b0; reserve_reg = '0; zero = 1'b0; zero_reg = '0;
      tick();
      cmp_en = 1'b1;
      tick();
      rst_i = 1'b0;
      settle();
      check("reset_wready", RLEN'(res_wready), RLEN'(1));
      check("reset_zero_ready", RLEN'(zero_ready), RLEN'(1));
      for (int p = 0; p < 3; p++) begin
         check("reset_valid", RLEN'(p_rvalid[p]), RLEN'(1));
         check("reset_rdata", p_rdata[p], RLEN'(0));
      end

      // reg2 rows 0x11..0x44, reg3 rows 0x301..0x304, reg1 row0 0x55
      for (int r = 0; r < N_ROWS; r++) wr(2, r, RLEN'(32'h11 * (r + 1)), r == N_ROWS - 1);
      for (int r = 0; r < N_ROWS; r++) wr(3, r, RLEN'(32'h301 + r), r == N_ROWS - 1);
      wr(1, 0, RLEN'(32'h55), 1'b1);
      p_raddr[2] = 3'd2; p_rrow[2] = 2'd1;
      settle();
      check("acc_reg2_row1_valid", RLEN'(p_rvalid[2]), RLEN'(1));
      check("acc_reg2_row1_data", p_rdata[2], RLEN'(32'h22));
      tick();

      // pending register blocks reads until the wlast write
      reserve = 1'b1; reserve_reg = 3'd5;
      tick();
      reserve = 1'b0;
      p_raddr[1] = 3'd5;
      settle();
      check("pend_after_reserve", RLEN'(p_rvalid[1]), RLEN'(0));
      tick();
      wr(5, 0, RLEN'(32'h500), 1'b0);
      settle();
      check("pend_after_nonlast", RLEN'(p_rvalid[1]), RLEN'(0));
      tick();
      res_waddr = 3'd5; res_wrow = 2'd1; res_wdata = RLEN'(32'h501); res_wlast = 1'b1; res_we = 1'b1;
      settle();
      check("pend_during_last", RLEN'(p_rvalid[1]), RLEN'(0));
      tick();
      res_we = 1'b0; res_wlast = 1'b0;
      settle();
      check("pend_cleared", RLEN'(p_rvalid[1]), RLEN'(1));
      tick();

      // same-cycle write/read returns pre-write data
      p_raddr[0] = 3'd1; p_rrow[0] = 2'd0;
      res_waddr = 3'd1; res_wrow = 2'd0; res_wdata = RLEN'(32'hAA); res_we = 1'b1; res_wlast = 1'b1;
      settle();
      check("rw_same_cycle_old", p_rdata[0], RLEN'(32'h55));
      tick();
      res_we = 1'b0; res_wlast = 1'b0;
      settle();
      check("rw_next_cycle_new", p_rdata[0], RLEN'(32'hAA));
      tick();

      // reserve and clear of the same register together: set wins
      p_raddr[1] = 3'd4;
      reserve = 1'b1; reserve_reg = 3'd4;
      res_waddr = 3'd4; res_wrow = 2'd0; res_wdata = RLEN'(32'h400); res_we = 1'b1; res_wlast = 1'b1;
      tick();
      res_we = 1'b0; res_wlast = 1'b0;
      settle();
      check("set_wins", RLEN'(p_rvalid[1]), RLEN'(0));
      tick();
      reserve = 1'b0;
      wr(4, 1, RLEN'(32'h401), 1'b1);
      settle();
      check("pend4_cleared", RLEN'(p_rvalid[1]), RLEN'(1));
      tick();

      // zero reg2 with a write to reg6 held across the operation
      p_raddr[2] = 3'd2; p_rrow[2] = 2'd0;
      zero = 1'b1; zero_reg = 3'd2;
      settle();
      check("zero_ready_idle", RLEN'(zero_ready), RLEN'(1));
      tick();
      zero = 1'b0;
      res_waddr = 3'd6; res_wrow = 2'd0; res_wdata = RLEN'(32'h66); res_we = 1'b1; res_wlast = 1'b1;
      for (int c = 1; c <= N_ROWS; c++) begin
         settle();
         check("zero_wready", RLEN'(res_wready), RLEN'(0));
         check("zero_reg2_invalid", RLEN'(p_rvalid[2]), RLEN'(0));
         check($sformatf("zero_done_c%0d", c), RLEN'(zero_done), RLEN'(c == N_ROWS));
         zero = (c == 2);
         zero_reg = 3'd3;
         tick();
      end
      zero = 1'b0;
      settle();
      check("zero_back_idle", RLEN'(res_wready), RLEN'(1));
      check("zero_done_gone", RLEN'(zero_done), RLEN'(0));
      tick();
      res_we = 1'b0; res_wlast = 1'b0;
      for (int r = 0; r < N_ROWS; r++) begin
         p_rrow[2] = RW'(r);
         p_raddr[0] = 3'd3; p_rrow[0] = RW'(r);
         settle();
         check("zeroed_reg2", p_rdata[2], RLEN'(0));
         check("zeroed_reg2_valid", RLEN'(p_rvalid[2]), RLEN'(1));
         v = RLEN'(32'h301 + r);
         check("reg3_unchanged", p_rdata[0], v);
         tick();
      end
      p_raddr[1] = 3'd6; p_rrow[1] = 2'd0;
      settle();
      check("held_write_landed", p_rdata[1], RLEN'(32'h66));
      tick();

      // weight port protocol: rows 0 then 2
      p_raddr[0] = 3'd0; p_rrow[0] = 2'd0; p_rlast[0] = 1'b0; p_rready[0] = 1'b1;
      tick();
      p_rrow[0] = 2'd2;
      tick();
      p_rready[0] = 1'b0;
      settle();
`ifdef MRF_PROTOCOL_CHECK_EN
      check("proto_err_set", RLEN'(proto_err), RLEN'(3'b001));
`else
      check("proto_err_off", RLEN'(proto_err), RLEN'(3'b000));
`endif
      tick(); tick();
`ifdef MRF_PROTOCOL_CHECK_EN
      check("proto_err_sticky", RLEN'(proto_err), RLEN'(3'b001));
`else
      check("proto_err_off_later", RLEN'(proto_err), RLEN'(3'b000));
`endif
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      settle();
      check("proto_err_reset", RLEN'(proto_err), RLEN'(3'b000));
      tick();

      // reset during zero of reg3, row 2
      for (int r = 0; r < N_ROWS; r++) wr(3, r, RLEN'(32'h301 + r), r == N_ROWS - 1);
      wr(0, 0, RLEN'(32'h77), 1'b1);
      zero = 1'b1; zero_reg = 3'd3;
      tick();
      zero = 1'b0;
      tick();
      tick();
      rst_i = 1'b1;
      settle();
      check("abort_no_done", RLEN'(zero_done), RLEN'(0));
      tick();
      rst_i = 1'b0;
      settle();
      check("abort_idle_zero_ready", RLEN'(zero_ready), RLEN'(1));
      check("abort_idle_wready", RLEN'(res_wready), RLEN'(1));
      check("abort_done_low", RLEN'(zero_done), RLEN'(0));
      tick();
      for (int g = 0; g < N_REGS; g++) begin
         for (int r = 0; r < N_ROWS; r++) begin
            p_raddr[0] = AW'(g); p_rrow[0] = RW'(r);
            settle();
            check("post_reset_storage", p_rdata[0], RLEN'(0));
            check("post_reset_valid", RLEN'(p_rvalid[0]), RLEN'(1));
            tick();
         end
      end

      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/mrf_responder.md
MRF_RESPONDER -- requirements
Module: mrf_responder

Interface
REQ-001 SHALL have parameter N_REGS, default 8: number of matrix registers.
REQ-002 SHALL have parameter MESH_WIDTH, default 4: rows per register (N_ROWS).
REQ-003 SHALL have parameter DATA_WIDTH, default 32: element width; RLEN = DATA_WIDTH*MESH_WIDTH.
REQ-004 clk_i  in  1  sole clock, rising edge.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 Per read port P in {weight, data, acc}, the port SHALL provide the following signals:
- P_raddr_i  in  $clog2(N_REGS)  register.
- P_rrowaddr_i  in  $clog2(N_ROWS)  row.
- P_rdata_ready_i  in  1  initiator consumes.
- P_rlast_i  in  1  last row.
- P_rdata_o  out  RLEN  row data.
- P_rdata_valid_o  out  1  data valid.
REQ-007 The write port SHALL provide the following signals:
- res_waddr_i  in  $clog2(N_REGS).
- res_wrowaddr_i  in  $clog2(N_ROWS).
- res_wdata_i  in  RLEN.
- res_we_i  in  1.
- res_wlast_i  in  1.
- res_wready_o  out  1.
REQ-008 The reservation port SHALL provide reserve_i  in  1  and reserve_reg_i  in  $clog2(N_REGS): mark a register pending-write.
REQ-009 The zero command port SHALL provide zero_i  in  1, zero_reg_i  in  $clog2(N_REGS), zero_ready_o  out  1 and zero_done_o  out  1 (one-cycle pulse).
REQ-010 SHALL provide proto_err_o  out  3: sticky per-port protocol error, bit0 weight, bit1 data, bit2 acc.

Function
REQ-011 Storage SHALL be N_REGS x N_ROWS rows of RLEN bits, held in flops.
REQ-012 P_rdata_o SHALL be combinational mem[P_raddr_i][P_rrowaddr_i]; the read latency is 0 cycles.
REQ-013 P_rdata_valid_o SHALL be ~pend_q[P_raddr_i] & ~(state==ZERO & zreg_q==P_raddr_i).
REQ-014 A read beat SHALL complete on P_rdata_valid_o & P_rdata_ready_i; the responder holds no read state otherwise.
REQ-015 res_wready_o SHALL be 1 in IDLE and 0 in ZERO.
REQ-016 A write beat on res_we_i & res_wready_o SHALL update mem[waddr][wrowaddr] at the next edge.
REQ-017 On a same-cycle read and write of the same row, the read SHALL return the pre-write data.
REQ-018 pend_q SHALL be a per-register bit, set at the edge after reserve_i=1.
REQ-019 pend_q[waddr] SHALL clear on a write beat with res_wlast_i=1.
REQ-020 A simultaneous reserve and clear of the same register SHALL leave pend_q set (set wins).
REQ-021 Reserving an already-pending register SHALL have no effect.
REQ-022 The FSM SHALL have states IDLE and ZERO. zero_ready_o = (state==IDLE).
REQ-023 zero_i in IDLE SHALL latch zreg_q and zrow_q=0 and go to ZERO.
REQ-024 In ZERO, each cycle SHALL write mem[zreg_q][zrow_q]=0 and increment zrow_q.
REQ-025 At zrow_q==N_ROWS-1, ZERO SHALL write the final row, pulse zero_done_o for one cycle and return to IDLE, N_ROWS cycles in total.
REQ-026 zero_i outside IDLE SHALL be ignored.
REQ-027 A write beat presented while in ZERO SHALL not be accepted (wready=0); the initiator holds it.
REQ-028 zero SHALL not alter pend_q.

Reset
REQ-029 On rst_i, at the next edge, all storage SHALL clear to 0.
REQ-030 On rst_i, pend_q SHALL clear to 0, state SHALL return to IDLE, and zrow_q, zreg_q and zero_done_o SHALL clear to 0.
REQ-031 On rst_i, proto_err_o SHALL clear to 0 and the per-port row checkers SHALL clear to 0.
REQ-032 Reset asserted mid-ZERO SHALL abort the operation with no zero_done_o pulse.
REQ-033 Reset SHALL override every simultaneous reserve, write or zero event.
REQ-034 After reset, res_wready_o=1, zero_ready_o=1, all P_rdata_valid_o=1 and P_rdata_o=0.

Configuration
REQ-035 With macro MRF_PROTOCOL_CHECK_EN defined, each read port SHALL keep an expected-row counter, 0 after reset.
REQ-036 With the macro defined, each read beat SHALL compare P_rrowaddr_i to the counter, and a mismatch SHALL set the port's proto_err_o bit.
REQ-037 With the macro defined, a read beat with P_rlast_i=1 while rrowaddr != N_ROWS-1, or with rlast=0 at rrowaddr==N_ROWS-1, SHALL set the port's error bit.
REQ-038 With the macro defined, the counter SHALL increment per beat and wrap to 0 on the beat with rlast=1.
REQ-039 Without the macro, proto_err_o SHALL be tied to 0, no checker logic SHALL exist, and data-path behaviour SHALL be identical.

Verification
REQ-040 Reset, write reg2 rows 0..3 with values 0x11..0x44 (wlast on row 3), then read the acc port reg2 row1 -> valid=1, rdata=0x22 in the same cycle.
REQ-041 reserve reg5, then read the data port reg5 -> valid=0 until the write beat to reg5 with wlast; valid=1 the cycle after.
REQ-042 zero_i reg2 -> wready=0 and reads of reg2 invalid for 4 cycles, zero_done_o pulses on cycle 4, then reg2 rows read 0 and reg3 is unchanged.
REQ-043 Same-cycle write 0xAA and read of reg1 row0 (old 0x55) -> rdata=0x55, then 0xAA on the next cycle.
REQ-044 MRF_PROTOCOL_CHECK_EN defined, weight port beats at rows 0,2 -> proto_err_o=3'b001 sticky; rst_i clears it.
REQ-045 Assert rst_i during ZERO row 2 -> no done pulse, state IDLE, all storage reads 0.
